status_flag_stack: RTL



---
 rtl/status_flag_stack_if.sv | 31 +++
 rtl/status_flag_stack.sv | 91 +++++++++
 2 files changed

// File: rtl/status_flag_stack_if.sv
// Control/status bundle between the branch/interrupt controller and the status flag stack.
interface status_flag_stack_if #(
    parameter int NUM_FLAGS   = 4,
    parameter int STACK_DEPTH = 4,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
);
    logic                 update_flags;
    logic [NUM_FLAGS-1:0] flag_mask;
    logic [NUM_FLAGS-1:0] flags_in;
    logic                 sw_write;
    logic [NUM_FLAGS-1:0] sw_data;
    logic                 push;
    logic                 pop;
    logic                 clear_err;
    logic [NUM_FLAGS-1:0] status_flags;
    logic [DW-1:0]        depth;
    logic                 stack_full;
    logic                 stack_empty;
    logic                 stack_ovf;
    logic                 stack_unf;

    modport master (
        output update_flags, flag_mask, flags_in, sw_write, sw_data, push, pop, clear_err,
        input  status_flags, depth, stack_full, stack_empty, stack_ovf, stack_unf
    );

    modport slave (
        input  update_flags, flag_mask, flags_in, sw_write, sw_data, push, pop, clear_err,
        output status_flags, depth, stack_full, stack_empty, stack_ovf, stack_unf
    );
endinterface

// File: rtl/status_flag_stack.sv
// Masked processor status register with a LIFO save/restore stack for interrupt entry/return.
module status_flag_stack #(
    parameter int NUM_FLAGS   = 4,
    parameter int STACK_DEPTH = 4,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    status_flag_stack_if.slave  bus
);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [NUM_FLAGS-1:0] stack_mem [STACK_DEPTH];
    logic [NUM_FLAGS-1:0] status_q;
    logic [NUM_FLAGS-1:0] status_d;
    logic [DW-1:0]        depth_q;
    logic                 ovf_q;
    logic                 unf_q;

    logic is_full;
    logic is_empty;
    logic push_only;
    logic pop_only;
    logic push_ok;
    logic pop_ok;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] top_idx;

    assign is_full   = (depth_q == DW'(STACK_DEPTH));
    assign is_empty  = (depth_q == '0);
    // Simultaneous push and pop cancel out: no stack motion and no error.
    assign push_only = bus.push & ~bus.pop;
    assign pop_only  = bus.pop & ~bus.push;
    assign push_ok   = push_only & ~is_full;
    assign pop_ok    = pop_only & ~is_empty;
    assign push_idx  = AW'(depth_q);
    assign top_idx   = AW'(depth_q - DW'(1));

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        status_d = status_q;
        if (pop_ok) begin
            status_d = stack_mem[top_idx];
        end else if (bus.sw_write) begin
            status_d = bus.sw_data;
        end else if (bus.update_flags) begin
            status_d = (status_q & ~bus.flag_mask) | (bus.flags_in & bus.flag_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            depth_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            if (push_ok) begin
                depth_q <= depth_q + DW'(1);
            end else if (pop_ok) begin
                depth_q <= depth_q - DW'(1);
            end
            // Setting an error has priority over clearing it in the same cycle.
            if (push_only && is_full) begin
                ovf_q <= 1'b1;
            end else if (bus.clear_err) begin
                ovf_q <= 1'b0;
            end
            if (pop_only && is_empty) begin
                unf_q <= 1'b1;
            end else if (bus.clear_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    // NOTE: stack storage is deliberately left out of reset; entries above depth are never read.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            stack_mem[push_idx] <= status_q;
        end
    end

    assign bus.status_flags = status_q;
    assign bus.depth        = depth_q;
    assign bus.stack_full   = is_full;
    assign bus.stack_empty  = is_empty;
    assign bus.stack_ovf    = ovf_q;
    assign bus.stack_unf    = unf_q;
endmodule
